// File: rtl/inv_mix_columns_iter_if.sv
`default_nettype none
// ============================================================================
//  Module      : inv_mix_columns_iter_if
//  Description : Handshake bundle for the iterative (Inv)MixColumns block.
//                The input side carries in_valid, in_ready and state_in
//                (plus encrypt when INV_MC_FWD_EN is defined). The output
//                side carries out_valid, out_ready and state_out.
//                The master modport belongs to the producer/consumer
//                environment. The slave modport belongs to the transform block.
//  Revision    : 1.0  initial release
// ============================================================================
interface inv_mix_columns_iter_if;

  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

`ifdef INV_MC_FWD_EN
  // 1 = forward MixColumns, 0 = InvMixColumns; sampled together with state_in
  logic         encrypt;

  modport master (
    output in_valid,
    output state_in,
    output encrypt,
    input  in_ready,
    input  out_valid,
    input  state_out,
    output out_ready
  );

  modport slave (
    input  in_valid,
    input  state_in,
    input  encrypt,
    output in_ready,
    output out_valid,
    output state_out,
    input  out_ready
  );
`else
  modport master (
    output in_valid,
    output state_in,
    input  in_ready,
    input  out_valid,
    input  state_out,
    output out_ready
  );

  modport slave (
    input  in_valid,
    input  state_in,
    output in_ready,
    output out_valid,
    output state_out,
    input  out_ready
  );
`endif

endinterface
`default_nettype wire

// File: rtl/inv_mix_columns_iter.sv
`default_nettype none
// ============================================================================
//  Module      : inv_mix_columns_iter
//  Description : Iterative AES InvMixColumns for the decryption round. The
//                block captures a 128-bit state through a valid/ready
//                handshake. It transforms COLS_PER_CYCLE columns per clock in
//                GF(2^8) mod 0x11b. It then holds the result stable until the
//                consumer accepts it.
//
//  Parameters  : COLS_PER_CYCLE - columns per clock. Legal values are 1, 2
//                                 and 4. The latency is 4/COLS_PER_CYCLE
//                                 cycles from accept to out_valid.
//
//  Ports       : clk            - single clock, all state updates on posedge
//                rst_n          - synchronous active-low reset
//                bus (slave)    - in_valid / in_ready / state_in
//                                 out_valid / out_ready / state_out
//                                 encrypt (only with INV_MC_FWD_EN)
//
//  Config      : INV_MC_FWD_EN  - when defined, bus.encrypt selects the
//                                 direction. encrypt=1 applies forward
//                                 MixColumns. encrypt=0 applies the inverse.
//                                 Both directions share one engine and have
//                                 the same timing.
//
//  Byte layout : byte k = state[127-8k -: 8]. Column c = bytes 4c..4c+3.
//
//  Revision    : 1.0  initial release
// ============================================================================
module inv_mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  inv_mix_columns_iter_if.slave bus
);

  // --------------------------------------------------------------------------
  // Parameter legality
  // --------------------------------------------------------------------------
  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [2:0] c_step     = 3'(COLS_PER_CYCLE);
  localparam logic [2:0] c_col_last = 3'd4;

  // --------------------------------------------------------------------------
  // GF(2^8) helpers
  // --------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // The engine computes one column in either direction. The inverse matrix
  // (0e 0b 0d 09) factors into the forward matrix (02 03 01 01) times a
  // preconditioning matrix (05 00 04 00, rotating). So the inverse first
  // folds 04*(a0^a2) into the even rows and 04*(a1^a3) into the odd rows.
  // It then runs the same forward network, with all multiples built from
  // chained xtime.
  function automatic logic [31:0] mix_column(input logic [31:0] col,
                                             input logic        fwd);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] u, v, t;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    u  = xtime(xtime(a0 ^ a2));
    v  = xtime(xtime(a1 ^ a3));
    if (!fwd) begin
      a0 = a0 ^ u;
      a1 = a1 ^ v;
      a2 = a2 ^ u;
      a3 = a3 ^ v;
    end
    // b_r = 02*a_r ^ 03*a_{r+1} ^ a_{r+2} ^ a_{r+3}
    //     = a_r ^ (a0^a1^a2^a3) ^ xtime(a_r ^ a_{r+1})
    t = a0 ^ a1 ^ a2 ^ a3;
    mix_column = {a0 ^ t ^ xtime(a0 ^ a1),
                  a1 ^ t ^ xtime(a1 ^ a2),
                  a2 ^ t ^ xtime(a2 ^ a3),
                  a3 ^ t ^ xtime(a3 ^ a0)};
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  fsm_t         r_fsm;
  logic [2:0]   r_col;        // index of the next column group (0..4)
  logic [127:0] r_data;       // working state; also the registered result
  logic         r_out_valid;
  logic         r_enc;        // direction latched with the state

  logic         w_in_ready;
  logic         w_enc_in;
  logic [2:0]   w_col_nxt;
  logic [127:0] w_next;

`ifdef INV_MC_FWD_EN
  assign w_enc_in = bus.encrypt;
`else
  assign w_enc_in = 1'b0;
`endif

  // The only combinational path through the block runs from out_ready to
  // in_ready. It lets a finished result leave in the same cycle that a new
  // input is accepted.
  assign w_in_ready    = (r_fsm == S_IDLE) || ((r_fsm == S_DONE) && bus.out_ready);
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.state_out = r_data;

  assign w_col_nxt = r_col + c_step;

  // --------------------------------------------------------------------------
  // Column engines. Each engine processes one column of the current group.
  // --------------------------------------------------------------------------
  logic [31:0] w_cols    [4];
  logic [1:0]  w_eng_idx [COLS_PER_CYCLE];
  logic [31:0] w_eng_out [COLS_PER_CYCLE];

  generate
    for (genvar c = 0; c < 4; c++) begin : g_col_split
      assign w_cols[c] = r_data[127-32*c -: 32];
    end

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_engine
      // The group start is always a multiple of COLS_PER_CYCLE. So this
      // index never wraps inside a group.
      assign w_eng_idx[g] = r_col[1:0] + 2'(g);
      assign w_eng_out[g] = mix_column(w_cols[w_eng_idx[g]], r_enc);
    end
  endgenerate

  // The processed columns are written back in place. All other columns keep
  // their current value.
  always_comb begin
    w_next = r_data;
    for (int c = 0; c < 4; c++) begin
      for (int g = 0; g < COLS_PER_CYCLE; g++) begin
        if (w_eng_idx[g] == 2'(c)) begin
          w_next[127-32*c -: 32] = w_eng_out[g];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm       <= S_IDLE;
      r_col       <= 3'd0;
      r_data      <= 128'h0;
      r_out_valid <= 1'b0;
      r_enc       <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_data <= bus.state_in;
            r_enc  <= w_enc_in;
            r_col  <= 3'd0;
            r_fsm  <= S_BUSY;
          end
        end

        S_BUSY: begin
          r_data <= w_next;
          r_col  <= w_col_nxt;
          if (w_col_nxt == c_col_last) begin
            r_fsm       <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end

        S_DONE: begin
          // The result stays put until the consumer takes it.
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (bus.in_valid) begin
              r_data <= bus.state_in;
              r_enc  <= w_enc_in;
              r_col  <= 3'd0;
              r_fsm  <= S_BUSY;
            end else begin
              r_fsm  <= S_IDLE;
            end
          end
        end

        default: begin
          r_fsm       <= S_IDLE;
          r_col       <= 3'd0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inv_mix_columns_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inv_mix_columns_iter
//  Description : Self-checking bench for inv_mix_columns_iter. The main DUT
//                has COLS_PER_CYCLE=1 and is checked with a scoreboard: the
//                driver queues expected results and a negedge monitor pops
//                and compares them. Two extra instances (2 and 4 columns per
//                clock) check data and latency on a fixed vector.
//                The reference model is a plain GF(2^8) matrix product.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_inv_mix_columns_iter;

  localparam logic [127:0] c_v1_in  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] c_v1_out = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] c_v2_in  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] c_v2_out = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;

  logic clk;
  logic rst_n;

  int n_total = 0;
  int n_pass  = 0;
  int n_pushed = 0;
  int n_recv   = 0;
  logic [127:0] sb[$];

  bit   rand_ready  = 0;
  logic ready_force = 0;
  bit   side_go     = 0;

  inv_mix_columns_iter_if u_if ();

  inv_mix_columns_iter #(.COLS_PER_CYCLE(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Reference model: GF(2^8) multiply and a rotating coefficient matrix
  // --------------------------------------------------------------------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] mc_model(input logic [127:0] s, input bit inv);
    logic [7:0]   coef[4];
    logic [127:0] r = '0;
    logic [7:0]   acc;
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc ^= gmul(coef[(j - row + 4) % 4], s[127 - 8*(4*c + j) -: 8]);
        r[127 - 8*(4*c + row) -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic chk(input bit ok, input string name,
                     input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // out_ready driver: either a forced level or random backpressure
  // --------------------------------------------------------------------------
  initial begin
    u_if.out_ready = 0;
    forever begin
      @(posedge clk);
      #2;
      u_if.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  // Call shortly after a posedge. Holds in_valid until accepted. Queues the
  // expected result when push is set.
  task automatic send(input logic [127:0] d, input bit enc, input logic [127:0] exp,
                      input bit push, output int waits);
    bit got = 0;
    waits = 0;
    u_if.in_valid = 1;
    u_if.state_in = d;
`ifdef INV_MC_FWD_EN
    u_if.encrypt  = enc;
`else
    if (enc) $display("note: encrypt requested without INV_MC_FWD_EN");
`endif
    while (!got && waits < 500) begin
      @(negedge clk);
      if (u_if.in_ready === 1'b1) got = 1;
      else waits++;
    end
    if (!got) chk(0, "accept_timeout", 128'(waits), 128'd500);
    @(posedge clk);
    if (got && push) begin
      sb.push_back(exp);
      n_pushed++;
    end
    #1;
    u_if.in_valid = 0;
    u_if.state_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // --------------------------------------------------------------------------
  // Monitor: pops the scoreboard on each transfer and checks hold while stalled
  // --------------------------------------------------------------------------
  initial begin
    logic [127:0] prev_data = '0;
    logic [127:0] exp;
    bit           prev_stall = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_stall = 0;
      end else begin
        if (prev_stall)
          chk(u_if.out_valid === 1'b1 && u_if.state_out === prev_data,
              "hold_while_stalled", u_if.state_out, prev_data);
        if (u_if.out_valid === 1'b1 && u_if.out_ready === 1'b1) begin
          if (sb.size() == 0) begin
            chk(0, "unexpected_output", u_if.state_out, '0);
          end else begin
            exp = sb.pop_front();
            chk(u_if.state_out === exp, "data", u_if.state_out, exp);
          end
          n_recv++;
        end
        prev_stall = (u_if.out_valid === 1'b1) && (u_if.out_ready !== 1'b1);
        prev_data  = u_if.state_out;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Extra instances: 2 and 4 columns per clock, same data, shorter latency
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 1; k < 3; k++) begin : g_side
      localparam int C   = 1 << k;
      localparam int LAT = 4 / C;
      bit done = 0;
      inv_mix_columns_iter_if u_sif ();
      inv_mix_columns_iter #(.COLS_PER_CYCLE(C)) u_sdut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_sif.slave)
      );
      initial begin
        u_sif.in_valid  = 0;
        u_sif.state_in  = '0;
        u_sif.out_ready = 0;
`ifdef INV_MC_FWD_EN
        u_sif.encrypt   = 0;
`endif
        wait (side_go);
        @(posedge clk);
        #1;
        u_sif.in_valid = 1;
        u_sif.state_in = c_v2_in;
        @(negedge clk);
        chk(u_sif.in_ready === 1'b1, $sformatf("c%0d_in_ready", C), 128'(u_sif.in_ready), 128'd1);
        @(posedge clk);
        #1;
        u_sif.in_valid = 0;
        u_sif.state_in = '1;
        for (int i = 0; i <= LAT; i++) begin
          @(negedge clk);
          chk(u_sif.out_valid === (i == LAT), $sformatf("c%0d_latency_cyc%0d", C, i),
              128'(u_sif.out_valid), 128'(i == LAT));
        end
        chk(u_sif.state_out === c_v2_out, $sformatf("c%0d_data", C), u_sif.state_out, c_v2_out);
        u_sif.out_ready = 1;
        @(posedge clk);
        #1;
        u_sif.out_ready = 0;
        @(negedge clk);
        chk(u_sif.out_valid === 1'b0 && u_sif.in_ready === 1'b1,
            $sformatf("c%0d_back_to_idle", C), 128'(u_sif.out_valid), 128'd0);
        done = 1;
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int          waits;
    int          bad;
    int          t;
    logic [127:0] x;
    logic [127:0] hold;
    bit          enc;

    u_if.in_valid = 0;
    u_if.state_in = '0;
`ifdef INV_MC_FWD_EN
    u_if.encrypt  = 0;
`endif
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;

    // Reset state
    @(negedge clk);
    chk(u_if.in_ready === 1'b1, "reset_in_ready", 128'(u_if.in_ready), 128'd1);
    chk(u_if.out_valid === 1'b0, "reset_out_valid", 128'(u_if.out_valid), 128'd0);
    chk(u_if.state_out === 128'h0, "reset_state_out", u_if.state_out, 128'h0);

    side_go = 1;

    // Vector 1 with latency check while out_ready is low
    @(posedge clk);
    #1;
    send(c_v1_in, 0, c_v1_out, 1, waits);
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      chk(u_if.out_valid === (i == 4), $sformatf("c1_latency_cyc%0d", i),
          128'(u_if.out_valid), 128'(i == 4));
    end

    // Backpressure: ten cycles stalled in DONE
    hold = u_if.state_out;
    chk(hold === c_v1_out, "v1_presented", hold, c_v1_out);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (u_if.in_ready !== 1'b0 || u_if.out_valid !== 1'b1 || u_if.state_out !== hold) bad++;
    end
    chk(bad == 0, "backpressure_cycles_bad", 128'(bad), 128'd0);

    // Release with a new input pending: accepted in the same cycle
    @(posedge clk);
    #1;
    ready_force = 1;
    send(c_v2_in, 0, c_v2_out, 1, waits);
    chk(waits == 0, "back_to_back_accept_waits", 128'(waits), 128'd0);

    // Drain, then reset in the middle of a transform
    t = 0;
    while (sb.size() != 0 && t < 100) begin @(posedge clk); t++; end
    #1;
    send(c_v1_in, 0, c_v1_out, 0, waits);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    chk(u_if.out_valid === 1'b0, "midbusy_reset_out_valid", 128'(u_if.out_valid), 128'd0);
    chk(u_if.state_out === 128'h0, "midbusy_reset_state_out", u_if.state_out, 128'h0);
    chk(u_if.in_ready === 1'b1, "midbusy_reset_in_ready", 128'(u_if.in_ready), 128'd1);
    @(posedge clk);
    #1;
    send(c_v2_in, 0, c_v2_out, 1, waits);

`ifdef INV_MC_FWD_EN
    send(c_v1_out, 1, c_v1_in, 1, waits);
`endif

    // Random round trips with input gaps and random backpressure
    rand_ready = 1;
    for (int n = 0; n < 1000; n++) begin
      x   = {$urandom, $urandom, $urandom, $urandom};
`ifdef INV_MC_FWD_EN
      enc = $urandom_range(0, 1) != 0;
`else
      enc = 0;
`endif
      if (enc) send(x, 1, mc_model(x, 0), 1, waits);
      else     send(mc_model(x, 0), 0, x, 1, waits);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Drain and account for every transaction
    rand_ready  = 0;
    ready_force = 1;
    t = 0;
    while (sb.size() != 0 && t < 1000) begin @(posedge clk); t++; end
    chk(sb.size() == 0, "scoreboard_drained", 128'(sb.size()), 128'd0);
    chk(n_recv == n_pushed, "transaction_count", 128'(n_recv), 128'(n_pushed));

    t = 0;
    while (!(g_side[1].done && g_side[2].done) && t < 200) begin @(posedge clk); t++; end
    chk(g_side[1].done && g_side[2].done, "side_instances_done",
        128'({g_side[1].done, g_side[2].done}), 128'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
